// File: rtl/fft_input_loader_if.sv
// Sample stream, FFT working-memory write port and FFT core handshake for the input loader.
// The master side feeds samples and reports FFT completion; the slave side is the loader.
interface fft_input_loader_if #(
  parameter int DATA_W = 32,
  parameter int N_LOG2 = 5
);
  logic                  s_valid;
  logic                  s_ready;
  logic [2*DATA_W-1:0]   s_data;
  logic                  s_last;
  logic                  mem_we;
  logic [N_LOG2-1:0]     mem_addr;
  logic [2*DATA_W-1:0]   mem_din;
  logic                  start_fft;
  logic                  fft_done;
  logic                  busy;
  logic                  frame_err;

  modport master (
    output s_valid, s_data, s_last, fft_done,
    input  s_ready, mem_we, mem_addr, mem_din, start_fft, busy, frame_err
  );

  modport slave (
    input  s_valid, s_data, s_last, fft_done,
    output s_ready, mem_we, mem_addr, mem_din, start_fft, busy, frame_err
  );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one frame of 2^N_LOG2 complex samples into FFT memory in bit-reversed order,
// then launches the FFT core and waits for it to finish before accepting the next frame.
//
// state | meaning
// LOAD  | accepting samples, writing each one a cycle later
// FLUSH | last sample's write in flight
// START | one-cycle start_fft pulse
// WAIT  | waiting for fft_done
module fft_input_loader #(
  parameter int DATA_W = 32,
  parameter int N_LOG2 = 5
) (
  input logic                clk,
  input logic                rst_n,
  fft_input_loader_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, FLUSH, START, WAIT} state_t;

  localparam logic [N_LOG2-1:0] K_MAX = '1;
  localparam logic [N_LOG2-1:0] K_ONE = N_LOG2'(1);

  state_t            state;
  state_t            state_nxt;
  logic [N_LOG2-1:0] k;
  logic              xfer;
  logic              k_is_max;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  assign bus.s_ready   = rst_n && (state == LOAD);
  assign bus.busy      = (state != LOAD);
  assign bus.start_fft = (state == START);

  assign xfer     = bus.s_valid && bus.s_ready;
  assign k_is_max = (k == K_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (xfer && k_is_max) state_nxt = FLUSH;
      FLUSH:   state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.fft_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // A full frame wraps k back to 0 naturally; an early s_last drops the partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k <= '0;
    end else if (state == WAIT && bus.fft_done) begin
      k <= '0;
    end else if (xfer) begin
      if (bus.s_last && !k_is_max) k <= '0;
      else                         k <= k + K_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.mem_we    <= xfer;
      bus.frame_err <= xfer && (bus.s_last != k_is_max);
      if (xfer) begin
        bus.mem_addr <= bitrev(k);
        bus.mem_din  <= bus.s_data;
      end
    end
  end

endmodule
